// File: rtl/modbus_pkg.sv
// Shared Modbus RTU definitions: CRC constants, response type encodings,
// frame lengths and the transmit framer state encoding.
package modbus_pkg;

   localparam logic [15:0] CRC_POLY = 16'hA001;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   localparam logic [1:0]  TX_ECHO  = 2'd0;
   localparam logic [1:0]  TX_READ  = 2'd1;
   localparam logic [1:0]  TX_EXC   = 2'd2;
   localparam logic [1:0]  TX_RSVD  = 2'd3;

   localparam logic [7:0]  EXC_FLAG      = 8'h80;
   localparam logic [7:0]  READ_BYTE_CNT = 8'h02;

   // Total frame lengths including the two CRC bytes
   localparam logic [3:0]  LEN_ECHO = 4'd8;
   localparam logic [3:0]  LEN_READ = 4'd7;
   localparam logic [3:0]  LEN_EXC  = 4'd5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CRC  = 3'd1,
      ST_SEND = 3'd2,
      ST_WAIT = 3'd3,
      ST_GAP  = 3'd4
   } tx_state_t;

   // Frame length for a response type; the reserved type never reaches here
   function automatic logic [3:0] frame_len(input logic [1:0] t);
      case (t)
         TX_ECHO: return LEN_ECHO;
         TX_READ: return LEN_READ;
         default: return LEN_EXC;
      endcase
   endfunction

endpackage

// File: rtl/frame_tx_if.sv
// Response-request and UART-side signals of the Modbus response framer.
// master = command handler plus UART, slave = frame_tx.
interface frame_tx_if;

   logic        tx_start;
   logic [1:0]  tx_type;
   logic [7:0]  dev_addr;
   logic [7:0]  func_code;
   logic [15:0] addr;
   logic [15:0] data;
   logic [7:0]  exc_code;
   logic        uart_tx_busy;
   logic        uart_tx_en;
   logic [7:0]  uart_tx_data;
   logic        tx_busy;
   logic        tx_done;

   modport master (
      output tx_start, tx_type, dev_addr, func_code, addr, data, exc_code,
      output uart_tx_busy,
      input  uart_tx_en, uart_tx_data, tx_busy, tx_done
   );

   modport slave (
      input  tx_start, tx_type, dev_addr, func_code, addr, data, exc_code,
      input  uart_tx_busy,
      output uart_tx_en, uart_tx_data, tx_busy, tx_done
   );

endinterface

// File: rtl/crc16_modbus_ser.sv
// Bit-serial Modbus CRC-16 (reflected 0xA001, init 0xFFFF). The first bit of
// a byte is consumed in the start cycle, the remaining seven in the following
// cycles, so a byte costs exactly 8 cycles and a new start is accepted as soon
// as busy drops.
module crc16_modbus_ser
   import modbus_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        init,
   input  logic        start,
   input  logic [7:0]  byte_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] crc
);

   logic [15:0] r_crc;
   logic [6:0]  r_shift;
   logic [2:0]  r_cnt;
   logic        r_done;

   // One LSB-first step of the reflected CRC
   function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[0] ^ b;
      return (c >> 1) ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

   // Shift one bit per cycle; done pulses the cycle after the eighth bit
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_crc   <= CRC_INIT;
         r_shift <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (init) begin
            r_crc <= CRC_INIT;
            r_cnt <= '0;
         end else if (start && (r_cnt == 3'd0)) begin
            r_crc   <= crc_bit(r_crc, byte_in[0]);
            r_shift <= byte_in[7:1];
            r_cnt   <= 3'd7;
         end else if (r_cnt != 3'd0) begin
            r_crc   <= crc_bit(r_crc, r_shift[0]);
            r_shift <= r_shift >> 1;
            r_cnt   <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
               r_done <= 1'b1;
            end
         end
      end
   end

   assign busy = (r_cnt != 3'd0);
   assign done = r_done;
   assign crc  = r_crc;

endmodule

// File: rtl/frame_tx.sv
// Modbus RTU slave response framer: latches a response request, builds the
// payload, appends the CRC, pushes bytes into the UART one at a time and
// holds off for the 3.5-character gap before reporting completion.
module frame_tx
   import modbus_pkg::*;
#(
   parameter int T35_CYCLES = 20000
) (
   input  logic      clk_in,
   input  logic      rst_n_in,
   frame_tx_if.slave bus
);

   localparam int               GAP_W    = (T35_CYCLES > 1) ? $clog2(T35_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(T35_CYCLES - 1);

   tx_state_t        r_state;
   tx_state_t        w_next;
   logic [2:0]       r_idx;
   logic [3:0]       r_len;
   logic [7:0]       r_buf [8];
   logic             r_mask;
   logic [GAP_W-1:0] r_gap_cnt;
   logic             r_tx_en;
   logic [7:0]       r_tx_data;
   logic             r_tx_busy;
   logic             r_tx_done;

   logic             w_accept;
   logic             w_crc_init;
   logic             w_crc_start;
   logic             w_append;
   logic             w_send;
   logic             w_next_byte;
   logic             w_enter_gap;
   logic             w_gap_end;
   logic             w_crc_busy;
   logic             w_crc_done;
   logic [15:0]      w_crc;
   logic [3:0]       w_plen;
   logic [3:0]       w_idx_ext;
   logic             w_last_byte;
   logic [2:0]       w_crc_lo_pos;
   logic [2:0]       w_crc_hi_pos;

   assign w_plen       = r_len - 4'd2;
   assign w_idx_ext    = {1'b0, r_idx};
   assign w_last_byte  = (w_idx_ext == (r_len - 4'd1));
   assign w_crc_lo_pos = w_plen[2:0];
   assign w_crc_hi_pos = w_plen[2:0] + 3'd1;

   crc16_modbus_ser u_crc (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .init     (w_crc_init),
      .start    (w_crc_start),
      .byte_in  (r_buf[r_idx]),
      .busy     (w_crc_busy),
      .done     (w_crc_done),
      .crc      (w_crc)
   );

   // State register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and per-cycle control strobes; a start in the tx_done cycle is refused
   always_comb begin
      w_next      = r_state;
      w_accept    = 1'b0;
      w_crc_init  = 1'b0;
      w_crc_start = 1'b0;
      w_append    = 1'b0;
      w_send      = 1'b0;
      w_next_byte = 1'b0;
      w_enter_gap = 1'b0;
      w_gap_end   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.tx_start && (bus.tx_type != TX_RSVD) && !r_tx_done) begin
               w_accept   = 1'b1;
               w_crc_init = 1'b1;
               w_next     = ST_CRC;
            end
         end
         ST_CRC: begin
            if (!w_crc_busy && (w_idx_ext < w_plen)) begin
               w_crc_start = 1'b1;
            end else if (w_crc_done && (w_idx_ext == w_plen)) begin
               w_append = 1'b1;
               w_next   = ST_SEND;
            end
         end
         ST_SEND: begin
            if (!bus.uart_tx_busy) begin
               w_send = 1'b1;
               w_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // The strobe cycle itself is masked: the UART has not raised busy yet
            if (!r_mask && !bus.uart_tx_busy) begin
               if (w_last_byte) begin
                  w_enter_gap = 1'b1;
                  w_next      = ST_GAP;
               end else begin
                  w_next_byte = 1'b1;
                  w_next      = ST_SEND;
               end
            end
         end
         ST_GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
               w_gap_end = 1'b1;
               w_next    = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Byte index, length, gap counter and registered outputs
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_idx     <= '0;
         r_len     <= '0;
         r_mask    <= 1'b0;
         r_gap_cnt <= '0;
         r_tx_en   <= 1'b0;
         r_tx_data <= 8'h00;
         r_tx_busy <= 1'b0;
         r_tx_done <= 1'b0;
      end else begin
         r_tx_en   <= w_send;
         r_mask    <= w_send;
         r_tx_done <= w_gap_end;
         if (w_accept) begin
            r_len     <= frame_len(bus.tx_type);
            r_idx     <= '0;
            r_tx_busy <= 1'b1;
         end else if (w_append) begin
            r_idx <= '0;
         end else if (w_crc_start || w_next_byte) begin
            r_idx <= r_idx + 3'd1;
         end
         if (w_gap_end) begin
            r_tx_busy <= 1'b0;
         end
         if (w_send) begin
            r_tx_data <= r_buf[r_idx];
         end
         if (w_enter_gap) begin
            r_gap_cnt <= '0;
         end else if (r_state == ST_GAP) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
         end
      end
   end

   // Frame buffer: payload latched on accept, CRC appended once computed
   always_ff @(posedge clk_in) begin
      if (w_accept) begin
         for (int i = 0; i < 8; i++) begin
            r_buf[i] <= 8'h00;
         end
         r_buf[0] <= bus.dev_addr;
         case (bus.tx_type)
            TX_ECHO: begin
               r_buf[1] <= bus.func_code;
               r_buf[2] <= bus.addr[15:8];
               r_buf[3] <= bus.addr[7:0];
               r_buf[4] <= bus.data[15:8];
               r_buf[5] <= bus.data[7:0];
            end
            TX_READ: begin
               r_buf[1] <= bus.func_code;
               r_buf[2] <= READ_BYTE_CNT;
               r_buf[3] <= bus.data[15:8];
               r_buf[4] <= bus.data[7:0];
            end
            default: begin
               r_buf[1] <= bus.func_code | EXC_FLAG;
               r_buf[2] <= bus.exc_code;
            end
         endcase
      end else if (w_append) begin
         r_buf[w_crc_lo_pos] <= w_crc[7:0];
         r_buf[w_crc_hi_pos] <= w_crc[15:8];
      end
   end

   assign bus.uart_tx_en   = r_tx_en;
   assign bus.uart_tx_data = r_tx_data;
   assign bus.tx_busy      = r_tx_busy;
   assign bus.tx_done      = r_tx_done;

endmodule

// File: tb/tb_frame_tx.sv
// Directed bench for frame_tx with a simple UART busy model and a byte monitor.
module tb_frame_tx;
   import modbus_pkg::*;

   localparam int T35 = 40;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   start_cyc = 0;
   int   uart_hold = 10;

   logic u_busy = 1'b0;
   int   u_cnt = 0;

   logic [7:0] cap_q [$];
   int         en_cyc_q [$];
   int         viol = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   logic       done_busy = 1'b0;
   int         last_fall_cyc = 0;
   logic       prev_busy = 1'b0;

   frame_tx_if bus ();

   frame_tx #(.T35_CYCLES(T35)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // UART model: busy for uart_hold cycles starting the cycle after a strobe
   always @(posedge clk) begin
      if (bus.uart_tx_en) begin
         u_busy <= 1'b1;
         u_cnt  <= uart_hold;
      end else if (u_cnt > 1) begin
         u_cnt <= u_cnt - 1;
      end else begin
         u_cnt  <= 0;
         u_busy <= 1'b0;
      end
   end
   assign bus.uart_tx_busy = u_busy;

   // Monitor on the inactive edge
   always @(negedge clk) begin
      if (bus.uart_tx_en) begin
         cap_q.push_back(bus.uart_tx_data);
         en_cyc_q.push_back(cyc);
         if (bus.uart_tx_busy) viol <= viol + 1;
      end
      if (bus.tx_done) begin
         done_cnt  <= done_cnt + 1;
         done_cyc  <= cyc;
         done_busy <= bus.tx_busy;
      end
      if (prev_busy && !u_busy) last_fall_cyc <= cyc;
      prev_busy <= u_busy;
   end

   function automatic logic [15:0] crc16_ref(input logic [7:0] b [8], input int n);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {8'h00, b[i]};
         for (int j = 0; j < 8; j++) begin
            if (c[0]) c = (c >> 1) ^ 16'hA001;
            else      c = c >> 1;
         end
      end
      return c;
   endfunction

   function automatic logic [7:0] cap_at(input int k);
      if (k < cap_q.size()) return cap_q[k];
      return 8'hxx;
   endfunction

   task automatic start_frame(input logic [1:0] t, input logic [7:0] dv, input logic [7:0] fc,
                              input logic [15:0] a, input logic [15:0] d, input logic [7:0] ex);
      @(posedge clk); #1;
      bus.tx_type   = t;
      bus.dev_addr  = dv;
      bus.func_code = fc;
      bus.addr      = a;
      bus.data      = d;
      bus.exc_code  = ex;
      bus.tx_start  = 1'b1;
      start_cyc     = cyc;
      @(posedge clk); #1;
      bus.tx_start  = 1'b0;
   endtask

   task automatic wait_done(input int dc0, input int bound);
      int n;
      n = 0;
      while (done_cnt == dc0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      total++;
      if (done_cnt == dc0) begin
         bad++;
         $display("FAIL done_timeout: no tx_done within %0d cycles, required one", bound);
      end
   endtask

   task automatic test_reset();
      bus.tx_start = 1'b0; bus.tx_type = 2'd0; bus.dev_addr = 8'h00; bus.func_code = 8'h00;
      bus.addr = 16'h0000; bus.data = 16'h0000; bus.exc_code = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (bus.uart_tx_en !== 1'b0) begin bad++; $display("FAIL rst_en: got %b want 0", bus.uart_tx_en); end
      total++; if (bus.uart_tx_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", bus.uart_tx_data); end
      total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.tx_busy); end
      total++; if (bus.tx_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.tx_done); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_echo();
      logic [7:0] exp [8];
      int base, dc;
      exp  = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
      base = cap_q.size();
      dc   = done_cnt;
      start_frame(TX_ECHO, 8'h01, 8'h06, 16'h0001, 16'h0003, 8'h00);
      @(negedge clk);
      total++; if (bus.tx_busy !== 1'b1) begin bad++; $display("FAIL echo_busy_rise: got %b want 1", bus.tx_busy); end
      wait_done(dc, 5000);
      total++; if (cap_q.size() - base !== 8) begin bad++; $display("FAIL echo_count: got %0d want 8", cap_q.size() - base); end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (cap_at(base + i) !== exp[i]) begin bad++; $display("FAIL echo_byte%0d: got %h want %h", i, cap_at(base + i), exp[i]); end
      end
      total++;
      if (en_cyc_q.size() <= base || en_cyc_q[base] - start_cyc !== 51) begin
         bad++; $display("FAIL echo_latency: got %0d want 51", (en_cyc_q.size() > base) ? en_cyc_q[base] - start_cyc : -1);
      end
      total++; if (done_cyc - last_fall_cyc !== T35 + 1) begin bad++; $display("FAIL echo_gap: got %0d want %0d", done_cyc - last_fall_cyc, T35 + 1); end
      total++; if (done_busy !== 1'b0) begin bad++; $display("FAIL echo_busy_at_done: got %b want 0", done_busy); end
      total++; if (viol !== 0) begin bad++; $display("FAIL echo_strobe_while_busy: got %0d want 0", viol); end
   endtask

   task automatic test_exception();
      logic [7:0] exp [8];
      int base, dc;
      exp  = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1, 8'h00, 8'h00, 8'h00};
      base = cap_q.size();
      dc   = done_cnt;
      start_frame(TX_EXC, 8'h01, 8'h03, 16'hFFFF, 16'hFFFF, 8'h02);
      wait_done(dc, 5000);
      total++; if (cap_q.size() - base !== 5) begin bad++; $display("FAIL exc_count: got %0d want 5", cap_q.size() - base); end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (cap_at(base + i) !== exp[i]) begin bad++; $display("FAIL exc_byte%0d: got %h want %h", i, cap_at(base + i), exp[i]); end
      end
      total++;
      if (en_cyc_q.size() <= base || en_cyc_q[base] - start_cyc !== 27) begin
         bad++; $display("FAIL exc_latency: got %0d want 27", (en_cyc_q.size() > base) ? en_cyc_q[base] - start_cyc : -1);
      end
   endtask

   task automatic test_read();
      logic [7:0] exp [8];
      logic [15:0] c;
      int base, dc;
      exp  = '{8'h01, 8'h03, 8'h02, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00};
      c    = crc16_ref(exp, 5);
      exp[5] = c[7:0];
      exp[6] = c[15:8];
      base = cap_q.size();
      dc   = done_cnt;
      start_frame(TX_READ, 8'h01, 8'h03, 16'h5555, 16'h000A, 8'h77);
      wait_done(dc, 5000);
      total++; if (cap_q.size() - base !== 7) begin bad++; $display("FAIL read_count: got %0d want 7", cap_q.size() - base); end
      for (int i = 0; i < 7; i++) begin
         total++;
         if (cap_at(base + i) !== exp[i]) begin bad++; $display("FAIL read_byte%0d: got %h want %h", i, cap_at(base + i), exp[i]); end
      end
      total++;
      if (en_cyc_q.size() <= base || en_cyc_q[base] - start_cyc !== 43) begin
         bad++; $display("FAIL read_latency: got %0d want 43", (en_cyc_q.size() > base) ? en_cyc_q[base] - start_cyc : -1);
      end
   endtask

   task automatic test_back_pressure();
      logic [7:0] exp [8];
      logic [15:0] c;
      int base, dc, v0;
      exp  = '{8'h11, 8'h06, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00};
      c    = crc16_ref(exp, 6);
      exp[6] = c[7:0];
      exp[7] = c[15:8];
      uart_hold = 1000;
      base = cap_q.size();
      dc   = done_cnt;
      v0   = viol;
      start_frame(TX_ECHO, 8'h11, 8'h06, 16'h1234, 16'hABCD, 8'h00);
      wait_done(dc, 20000);
      total++; if (cap_q.size() - base !== 8) begin bad++; $display("FAIL bp_count: got %0d want 8", cap_q.size() - base); end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (cap_at(base + i) !== exp[i]) begin bad++; $display("FAIL bp_byte%0d: got %h want %h", i, cap_at(base + i), exp[i]); end
      end
      for (int i = 0; i + 1 < 8 && base + i + 1 < en_cyc_q.size(); i++) begin
         total++;
         if (en_cyc_q[base + i + 1] - en_cyc_q[base + i] < 1001) begin
            bad++; $display("FAIL bp_spacing%0d: got %0d want >=1001", i, en_cyc_q[base + i + 1] - en_cyc_q[base + i]);
         end
      end
      total++; if (viol !== v0) begin bad++; $display("FAIL bp_strobe_while_busy: got %0d want %0d", viol, v0); end
      uart_hold = 10;
   endtask

   task automatic test_ignored_starts();
      logic [7:0] exp [8];
      logic [15:0] c;
      int base, n, dc;
      base = cap_q.size();
      start_frame(TX_RSVD, 8'h01, 8'h06, 16'h0001, 16'h0003, 8'h00);
      repeat (60) @(negedge clk);
      total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL rsvd_busy: got %b want 0", bus.tx_busy); end
      total++; if (cap_q.size() !== base) begin bad++; $display("FAIL rsvd_bytes: got %0d want 0", cap_q.size() - base); end

      exp  = '{8'h02, 8'h06, 8'h00, 8'h10, 8'h00, 8'hFF, 8'h00, 8'h00};
      c    = crc16_ref(exp, 6);
      exp[6] = c[7:0];
      exp[7] = c[15:8];
      dc   = done_cnt;
      start_frame(TX_ECHO, 8'h02, 8'h06, 16'h0010, 16'h00FF, 8'h00);
      n = 0;
      while (cap_q.size() < base + 2 && n < 2000) begin @(negedge clk); n++; end
      start_frame(TX_EXC, 8'h09, 8'h03, 16'h0000, 16'h0000, 8'h04);
      start_frame(TX_RSVD, 8'h0A, 8'h03, 16'h0000, 16'h0000, 8'h04);
      n = 0;
      while (bus.tx_done !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
      total++;
      if (bus.tx_done !== 1'b1) begin
         bad++; $display("FAIL ign_done_seen: got %b want 1", bus.tx_done);
      end else begin
         bus.tx_type = TX_READ; bus.dev_addr = 8'h33; bus.func_code = 8'h03; bus.data = 16'h1111;
         bus.tx_start = 1'b1;
         @(posedge clk); #1;
         bus.tx_start = 1'b0;
      end
      repeat (80) @(negedge clk);
      total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL ign_busy_after_done: got %b want 0", bus.tx_busy); end
      total++; if (done_cnt - dc !== 1) begin bad++; $display("FAIL ign_done_count: got %0d want 1", done_cnt - dc); end
      total++; if (cap_q.size() - base !== 8) begin bad++; $display("FAIL ign_count: got %0d want 8", cap_q.size() - base); end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (cap_at(base + i) !== exp[i]) begin bad++; $display("FAIL ign_byte%0d: got %h want %h", i, cap_at(base + i), exp[i]); end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] exp [8];
      logic [15:0] c;
      int base, n, dc;
      exp  = '{8'h05, 8'h06, 8'h7F, 8'h20, 8'h5A, 8'h5A, 8'h00, 8'h00};
      c    = crc16_ref(exp, 6);
      exp[6] = c[7:0];
      exp[7] = c[15:8];
      base = cap_q.size();
      start_frame(TX_ECHO, 8'h05, 8'h06, 16'h7F20, 16'h5A5A, 8'h00);
      n = 0;
      while (cap_q.size() < base + 3 && n < 2000) begin @(negedge clk); n++; end
      @(posedge clk); #2;
      total++; if (bus.uart_tx_data !== 8'h7F) begin bad++; $display("FAIL mid_pre_data: got %h want 7f", bus.uart_tx_data); end
      rst_n = 1'b0;
      #1;
      total++; if (bus.uart_tx_en !== 1'b0) begin bad++; $display("FAIL mid_rst_en: got %b want 0", bus.uart_tx_en); end
      total++; if (bus.uart_tx_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data: got %h want 00", bus.uart_tx_data); end
      total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", bus.tx_busy); end
      total++; if (bus.tx_done !== 1'b0) begin bad++; $display("FAIL mid_rst_done: got %b want 0", bus.tx_done); end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (80) @(negedge clk);
      total++; if (cap_q.size() - base !== 3) begin bad++; $display("FAIL mid_abort_bytes: got %0d want 3", cap_q.size() - base); end

      base = cap_q.size();
      dc   = done_cnt;
      start_frame(TX_ECHO, 8'h05, 8'h06, 16'h7F20, 16'h5A5A, 8'h00);
      wait_done(dc, 5000);
      total++; if (cap_q.size() - base !== 8) begin bad++; $display("FAIL mid_new_count: got %0d want 8", cap_q.size() - base); end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (cap_at(base + i) !== exp[i]) begin bad++; $display("FAIL mid_new_byte%0d: got %h want %h", i, cap_at(base + i), exp[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_echo();
      test_exception();
      test_read();
      test_back_pressure();
      test_ignored_starts();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
